// File: rtl/dca_store_pkg.sv
// ---------------------------------------------------------------------------
// dca_store_pkg
// Shared definitions for the matrix store path: FSM state encoding used by
// dca_matrix_store_packer, the AXI write-response codes, and the helper
// that derives how many AXI data beats make up one tensor row.
// ---------------------------------------------------------------------------
package dca_store_pkg;

   // Store FSM states, kept as plain constants so older tools that only see
   // a two-bit vector still decode them the same way.
   typedef logic [1:0] state_t;
   localparam state_t ST_IDLE   = 2'd0;
   localparam state_t ST_RUN    = 2'd1;
   localparam state_t ST_WAIT_B = 2'd2;
   localparam state_t ST_DONE   = 2'd3;

   // AXI BRESP encodings
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_EXOKAY = 2'b01;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   // Number of AXI data beats needed to carry one tensor row
   function automatic int calcBeats(input int rowBits, input int dataBits);
      return rowBits / dataBits;
   endfunction

endpackage

// File: rtl/dca_row_serializer.sv
// ---------------------------------------------------------------------------
// dca_row_serializer
// Holds one tensor row and slices it into AXI W beats, lowest element first.
// A new row may be loaded in the same cycle that the last beat of the
// current row handshakes, so rows stream with no bubble.
//
// Ports:
//   clk, rst     clock and synchronous active-high reset
//   load_i       row handshake from the top; captures row_i
//   row_i        full tensor row, element 0 in the LSBs
//   enable_i     top allows beats (AW for this row already accepted)
//   wready_i     AXI W ready
//   full_o       holding register contains a row with beats left
//   wvalid_o     AXI W valid
//   wdata_o      current beat
//   wlast_o      current beat is the final one of the row
//   rowDone_o    final beat of the row handshakes this cycle
// ---------------------------------------------------------------------------
module dca_row_serializer
   import dca_store_pkg::*;
#(
   parameter int BW_ROW  = 128,
   parameter int BW_DATA = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               load_i,
   input  logic [BW_ROW-1:0]  row_i,
   input  logic               enable_i,
   input  logic               wready_i,
   output logic               full_o,
   output logic               wvalid_o,
   output logic [BW_DATA-1:0] wdata_o,
   output logic               wlast_o,
   output logic               rowDone_o
);

   localparam int BEATS   = calcBeats(BW_ROW, BW_DATA);
   localparam int BW_BEAT = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam logic [BW_BEAT-1:0] LAST_BEAT = BW_BEAT'(BEATS - 1);

   logic [BW_ROW-1:0]  hold_q, hold_d;
   logic [BW_BEAT-1:0] beat_q, beat_d;
   logic               full_q, full_d;
   logic               beatFire;
   logic               atLast;

   // The holding register shifts right after each beat, so the outgoing
   // beat is always sitting in the low bits.
   assign atLast    = (beat_q == LAST_BEAT);
   assign wvalid_o  = full_q && enable_i;
   assign wdata_o   = hold_q[BW_DATA-1:0];
   assign wlast_o   = wvalid_o && atLast;
   assign beatFire  = wvalid_o && wready_i;
   assign rowDone_o = beatFire && atLast;
   assign full_o    = full_q;

   // Next-state: advance on each accepted beat; a load wins over draining
   // because it only happens when the register is empty or just emptied.
   always_comb begin
      hold_d = hold_q;
      beat_d = beat_q;
      full_d = full_q;
      if (beatFire) begin
         hold_d = hold_q >> BW_DATA;
         if (atLast) begin
            beat_d = '0;
            full_d = 1'b0;
         end else begin
            beat_d = beat_q + 1'b1;
         end
      end
      if (load_i) begin
         hold_d = row_i;
         beat_d = '0;
         full_d = 1'b1;
      end
   end

   // State registers
   always_ff @(posedge clk) begin
      if (rst) begin
         hold_q <= '0;
         beat_q <= '0;
         full_q <= 1'b0;
      end else begin
         hold_q <= hold_d;
         beat_q <= beat_d;
         full_q <= full_d;
      end
   end

endmodule

// File: rtl/dca_matrix_store_packer.sv
// ---------------------------------------------------------------------------
// dca_matrix_store_packer
// Takes a store command and a stream of tensor rows and turns each row into
// one AXI4 write burst (AW beat, then BEATS W beats), then waits for every
// B response before pulsing done.
//
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   cmd_valid/ready, cmd_*         store command (base, stride, row count)
//   row_valid/ready, row_data      tensor rows from the compute array
//   aw*, w*, b*                    AXI4 write channels
//   busy                           command in progress
//   done                           one-cycle completion pulse
//   error                          sticky error response seen this command
// ---------------------------------------------------------------------------
module dca_matrix_store_packer
   import dca_store_pkg::*;
#(
   parameter int BW_AXI_ADDR = 32,
   parameter int BW_AXI_DATA = 32,
   parameter int MATRIX_SIZE = 4,
   parameter int BW_ELEMENT  = 32,
   parameter int BW_NUM_ROW  = 8,
   parameter int BW_TENSOR_ROW = MATRIX_SIZE * BW_ELEMENT
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     cmd_valid,
   output logic                     cmd_ready,
   input  logic [BW_AXI_ADDR-1:0]   cmd_base_addr,
   input  logic [BW_AXI_ADDR-1:0]   cmd_stride,
   input  logic [BW_NUM_ROW-1:0]    cmd_num_row,
   input  logic                     row_valid,
   output logic                     row_ready,
   input  logic [BW_TENSOR_ROW-1:0] row_data,
   output logic                     awvalid,
   input  logic                     awready,
   output logic [BW_AXI_ADDR-1:0]   awaddr,
   output logic [7:0]               awlen,
   output logic                     wvalid,
   input  logic                     wready,
   output logic [BW_AXI_DATA-1:0]   wdata,
   output logic [BW_AXI_DATA/8-1:0] wstrb,
   output logic                     wlast,
   input  logic                     bvalid,
   output logic                     bready,
   input  logic [1:0]               bresp,
   output logic                     busy,
   output logic                     done,
   output logic                     error
);

   localparam int BEATS = calcBeats(BW_TENSOR_ROW, BW_AXI_DATA);

   state_t                  state_q, state_d;
   logic [BW_AXI_ADDR-1:0]  awAddr_q, awAddr_d;
   logic [BW_AXI_ADDR-1:0]  stride_q, stride_d;
   logic [BW_NUM_ROW-1:0]   numRow_q, numRow_d;
   logic [BW_NUM_ROW-1:0]   awCnt_q, awCnt_d;
   logic [BW_NUM_ROW-1:0]   rowCnt_q, rowCnt_d;
   logic [BW_NUM_ROW-1:0]   wRowCnt_q, wRowCnt_d;
   logic [BW_NUM_ROW-1:0]   bCnt_q, bCnt_d;
   logic                    awValid_q, awValid_d;
   logic                    error_q, error_d;

   logic cmdFire, awFire, rowFire, bFire;
   logic serFull, rowDone, wEnable, badResp;

   // A row's W beats may only go out once its AW has been accepted; the
   // row sitting in the serializer is always row number wRowCnt_q.
   assign wEnable   = (awCnt_q > wRowCnt_q);

   assign cmd_ready = (state_q == ST_IDLE) && !rst;
   assign row_ready = (state_q == ST_RUN) && (rowCnt_q < numRow_q) &&
                      (!serFull || rowDone);
   assign awvalid   = awValid_q;
   assign awaddr    = awAddr_q;
   assign awlen     = 8'(BEATS - 1);
   assign wstrb     = '1;
   assign bready    = (state_q == ST_RUN) || (state_q == ST_WAIT_B);
   assign busy      = (state_q == ST_RUN) || (state_q == ST_WAIT_B);
   assign done      = (state_q == ST_DONE);
   assign error     = error_q;

   assign cmdFire = cmd_valid && cmd_ready;
   assign awFire  = awValid_q && awready;
   assign rowFire = row_valid && row_ready;
   assign bFire   = bvalid && bready;
   assign badResp = (bresp == RESP_SLVERR) || (bresp == RESP_DECERR);

   dca_row_serializer #(
      .BW_ROW  (BW_TENSOR_ROW),
      .BW_DATA (BW_AXI_DATA)
   ) u_serializer (
      .clk       (clk),
      .rst       (rst),
      .load_i    (rowFire),
      .row_i     (row_data),
      .enable_i  (wEnable),
      .wready_i  (wready),
      .full_o    (serFull),
      .wvalid_o  (wvalid),
      .wdata_o   (wdata),
      .wlast_o   (wlast),
      .rowDone_o (rowDone)
   );

   // Channel bookkeeping first (AW address accumulator, row/W/B counters,
   // sticky error), then the FSM. The address is a running sum so no
   // multiplier is needed; it wraps modulo the address width on its own.
   // Handshakes on all channels in one cycle are applied together.
   always_comb begin
      state_d   = state_q;
      awAddr_d  = awAddr_q;
      stride_d  = stride_q;
      numRow_d  = numRow_q;
      awCnt_d   = awCnt_q;
      rowCnt_d  = rowCnt_q;
      wRowCnt_d = wRowCnt_q;
      bCnt_d    = bCnt_q;
      awValid_d = awValid_q;
      error_d   = error_q;

      if (awFire) begin
         awAddr_d  = awAddr_q + stride_q;
         awCnt_d   = awCnt_q + 1'b1;
         awValid_d = ((awCnt_q + 1'b1) != numRow_q);
      end
      if (rowFire) begin
         rowCnt_d = rowCnt_q + 1'b1;
      end
      if (rowDone) begin
         wRowCnt_d = wRowCnt_q + 1'b1;
      end
      if (bFire) begin
         bCnt_d = bCnt_q + 1'b1;
         if (badResp) begin
            error_d = 1'b1;
         end
      end

      case (state_q)
         ST_IDLE: begin
            if (cmdFire) begin
               awAddr_d  = cmd_base_addr;
               stride_d  = cmd_stride;
               numRow_d  = cmd_num_row;
               awCnt_d   = '0;
               rowCnt_d  = '0;
               wRowCnt_d = '0;
               bCnt_d    = '0;
               error_d   = 1'b0;
               awValid_d = (cmd_num_row != '0);
               state_d   = (cmd_num_row == '0) ? ST_DONE : ST_RUN;
            end
         end
         ST_RUN: begin
            if (rowDone && ((wRowCnt_q + 1'b1) == numRow_q)) begin
               state_d = ST_WAIT_B;
            end
         end
         ST_WAIT_B: begin
            if (bCnt_d == numRow_q) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State registers; reset abandons any command in flight
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         awAddr_q  <= '0;
         stride_q  <= '0;
         numRow_q  <= '0;
         awCnt_q   <= '0;
         rowCnt_q  <= '0;
         wRowCnt_q <= '0;
         bCnt_q    <= '0;
         awValid_q <= 1'b0;
         error_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         awAddr_q  <= awAddr_d;
         stride_q  <= stride_d;
         numRow_q  <= numRow_d;
         awCnt_q   <= awCnt_d;
         rowCnt_q  <= rowCnt_d;
         wRowCnt_q <= wRowCnt_d;
         bCnt_q    <= bCnt_d;
         awValid_q <= awValid_d;
         error_q   <= error_d;
      end
   end

endmodule
